// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants and types for the ROM fetch arbiter: address geometry,
// the NOP fill word and port identifiers.
package rom_fetch_arbiter_pkg;

    localparam int          ROM_ADDR_W = 5;
    localparam int          WORD_SHIFT = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [0:0] {
        PORT_FETCH = 1'b0,
        PORT_DBG   = 1'b1
    } port_e;

    // Flags a byte address that is misaligned or lies beyond the ROM word range.
    function automatic logic addr_bad(input logic [31:0] byte_addr, input int addr_w);
        logic [31:0] hi_mask;
        hi_mask  = ~((32'd1 << (addr_w + WORD_SHIFT)) - 32'd1);
        addr_bad = (byte_addr[1:0] != 2'b00) || ((byte_addr & hi_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_slot.sv
// rom_rsp_slot: single-entry response register with valid/ready hold.
// A load in the same cycle as a handshake replaces the old response.
module rom_rsp_slot
    import rom_fetch_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_err,
    input  logic        rsp_ready,
    output logic        can_load,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        rsp_err_r;

    assign can_load  = !rsp_valid_r || rsp_ready;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

    // Response register: refill on load, drop valid on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= NOP_INSTR;
            rsp_err_r   <= 1'b0;
        end else if (load) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= load_data;
            rsp_err_r   <= load_err;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Two-port arbiter in front of the combinational instruction ROM: fetch has
// priority, debug is forced after STARVE_LIMIT contested losses.
// Optional address checking is enabled with `define ROM_ARB_ADDR_CHECK_EN.
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ROM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rsp_valid,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              f_rsp_ready,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    output logic              d_gnt,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    input  logic              d_rsp_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic              f_free_s;
    logic              d_free_s;
    logic              f_elig_s;
    logic              d_elig_s;
    logic              contest_s;
    logic              win_any_s;
    port_e             win_port_s;
    logic [31:0]       sel_addr_s;
    logic              sel_err_s;
    logic [31:0]       load_data_s;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [CNT_W-1:0]  starve_cnt_r;

    assign f_elig_s  = f_req && f_free_s;
    assign d_elig_s  = d_req && d_free_s;
    assign contest_s = f_elig_s && d_elig_s;

    // Winner selection: fetch first unless debug has been starved long enough.
    always_comb begin
        win_any_s  = 1'b0;
        win_port_s = PORT_FETCH;
        if (contest_s) begin
            win_any_s  = 1'b1;
            win_port_s = (starve_cnt_r == CNT_MAX) ? PORT_DBG : PORT_FETCH;
        end else if (f_elig_s) begin
            win_any_s  = 1'b1;
            win_port_s = PORT_FETCH;
        end else if (d_elig_s) begin
            win_any_s  = 1'b1;
            win_port_s = PORT_DBG;
        end else begin
            win_any_s  = 1'b0;
            win_port_s = PORT_FETCH;
        end
    end

    assign f_gnt      = win_any_s && (win_port_s == PORT_FETCH);
    assign d_gnt      = win_any_s && (win_port_s == PORT_DBG);
    assign sel_addr_s = (win_port_s == PORT_DBG) ? d_addr : f_addr;
    assign rom_addr   = win_any_s ? sel_addr_s[ADDR_W+1:WORD_SHIFT] : rom_addr_r;

`ifdef ROM_ARB_ADDR_CHECK_EN
    assign sel_err_s = addr_bad(sel_addr_s, ADDR_W);
`else
    // Byte-offset and out-of-range bits carry no meaning without checking.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{sel_addr_s[31:ADDR_W+2], sel_addr_s[1:0]};
    assign sel_err_s          = 1'b0;
`endif

    assign load_data_s = sel_err_s ? NOP_INSTR : rom_instr;

    // Last granted word address, presented to the ROM in idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_r <= {ADDR_W{1'b0}};
        end else if (win_any_s) begin
            rom_addr_r <= sel_addr_s[ADDR_W+1:WORD_SHIFT];
        end else begin
            rom_addr_r <= rom_addr_r;
        end
    end

    // Count contested fetch wins; any debug win or idle debug port resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!d_req || d_gnt) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (contest_s && f_gnt && (starve_cnt_r < CNT_MAX)) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    rom_rsp_slot u_f_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (f_gnt),
        .load_data (load_data_s),
        .load_err  (sel_err_s),
        .rsp_ready (f_rsp_ready),
        .can_load  (f_free_s),
        .rsp_valid (f_rsp_valid),
        .rsp_data  (f_rsp_data),
        .rsp_err   (f_rsp_err)
    );

    rom_rsp_slot u_d_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (d_gnt),
        .load_data (load_data_s),
        .load_err  (sel_err_s),
        .rsp_ready (d_rsp_ready),
        .can_load  (d_free_s),
        .rsp_valid (d_rsp_valid),
        .rsp_data  (d_rsp_data),
        .rsp_err   (d_rsp_err)
    );

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter with a small test-memory ROM image.
// Expected values follow ROM_ARB_ADDR_CHECK_EN when it is defined.
module tb_rom_fetch_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic        f_rsp_ready;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic        d_rsp_ready;
    logic [4:0]  rom_addr;
    logic [31:0] rom_instr;

    logic [31:0] rom_mem [0:31];
    int          n_vec;
    int          n_miss;

    assign rom_instr = rom_mem[rom_addr];

    rom_fetch_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_err   (f_rsp_err),
        .f_rsp_ready (f_rsp_ready),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_gnt       (d_gnt),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err),
        .d_rsp_ready (d_rsp_ready),
        .rom_addr    (rom_addr),
        .rom_instr   (rom_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_d;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 32; i++) rom_mem[i] = 32'h1000_0000 + 32'(i);
        rom_mem[0]  = 32'h2401_0001;
        rom_mem[1]  = 32'h2402_0002;
        rom_mem[2]  = 32'h0022_1820;
        rom_mem[3]  = 32'hac03_0004;
        rom_mem[4]  = 32'h8c04_0004;
        rom_mem[5]  = 32'hac01_0000;
        rom_mem[31] = 32'h8c0a_0008;

        rst_n = 1'b0;
        f_req = 1'b0; f_addr = 32'd0; f_rsp_ready = 1'b1;
        d_req = 1'b0; d_addr = 32'd0; d_rsp_ready = 1'b1;
        #12;
        check_vec("rst_f_valid", 32'(f_rsp_valid), 32'd0);
        check_vec("rst_d_valid", 32'(d_rsp_valid), 32'd0);
        check_vec("rst_f_data", f_rsp_data, 32'd0);
        check_vec("rst_d_err", 32'(d_rsp_err), 32'd0);
        check_vec("rst_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single fetch of word 0
        f_req = 1'b1; f_addr = 32'h0;
        #1;
        check_vec("first_f_gnt", 32'(f_gnt), 32'd1);
        tick();
        check_vec("first_f_valid", 32'(f_rsp_valid), 32'd1);
        check_vec("first_f_data", f_rsp_data, 32'h2401_0001);
        check_vec("first_f_err", 32'(f_rsp_err), 32'd0);

        // Back-to-back stream 0x0..0x14
        for (int i = 0; i < 6; i++) begin
            f_addr = 32'(i * 4);
            #1;
            check_vec("stream_gnt", 32'(f_gnt), 32'd1);
            tick();
            check_vec("stream_valid", 32'(f_rsp_valid), 32'd1);
            check_vec("stream_data", f_rsp_data, rom_mem[i]);
        end
        check_vec("stream_last", f_rsp_data, 32'hac01_0000);
        f_req = 1'b0;
        #1;
        check_vec("idle_rom_addr_hold", 32'(rom_addr), 32'd5);
        check_vec("idle_f_gnt", 32'(f_gnt), 32'd0);
        tick();
        check_vec("idle_f_valid_clr", 32'(f_rsp_valid), 32'd0);

        // Both ports continuously: F,F,F,F,D repeating
        f_req = 1'b1; f_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'h7c;
        for (int c = 0; c < 10; c++) begin
            exp_d = ((c % 5) == 4);
            #1;
            check_vec("pat_f_gnt", 32'(f_gnt), 32'(!exp_d));
            check_vec("pat_d_gnt", 32'(d_gnt), 32'(exp_d));
            tick();
            if (exp_d) begin
                check_vec("pat_d_valid", 32'(d_rsp_valid), 32'd1);
                check_vec("pat_d_data", d_rsp_data, 32'h8c0a_0008);
                check_vec("pat_f_valid_clr", 32'(f_rsp_valid), 32'd0);
            end else begin
                check_vec("pat_f_valid", 32'(f_rsp_valid), 32'd1);
                check_vec("pat_f_data", f_rsp_data, 32'h2401_0001);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();

        // Fetch consumer stalls: debug keeps every cycle
        f_req = 1'b1; f_addr = 32'h4; f_rsp_ready = 1'b0;
        d_req = 1'b1; d_addr = 32'h7c;
        #1;
        check_vec("stall_first_f_gnt", 32'(f_gnt), 32'd1);
        tick();
        check_vec("stall_f_data0", f_rsp_data, 32'h2402_0002);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_vec("stall_f_gnt", 32'(f_gnt), 32'd0);
            check_vec("stall_d_gnt", 32'(d_gnt), 32'd1);
            tick();
            check_vec("stall_f_valid", 32'(f_rsp_valid), 32'd1);
            check_vec("stall_f_data", f_rsp_data, 32'h2402_0002);
            check_vec("stall_d_data", d_rsp_data, 32'h8c0a_0008);
        end
        f_rsp_ready = 1'b1;
        #1;
        check_vec("unstall_f_gnt", 32'(f_gnt), 32'd1);
        check_vec("unstall_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        check_vec("unstall_f_data", f_rsp_data, 32'h2402_0002);

        // Address checking on the debug port
        f_req = 1'b0;
        d_addr = 32'h2;
        #1;
        check_vec("chk_d_gnt", 32'(d_gnt), 32'd1);
        check_vec("chk_rom_addr", 32'(rom_addr), 32'd0);
        tick();
`ifdef ROM_ARB_ADDR_CHECK_EN
        check_vec("mis_err", 32'(d_rsp_err), 32'd1);
        check_vec("mis_data", d_rsp_data, 32'd0);
`else
        check_vec("mis_err", 32'(d_rsp_err), 32'd0);
        check_vec("mis_data", d_rsp_data, 32'h2401_0001);
`endif
        d_addr = 32'h80;
        tick();
`ifdef ROM_ARB_ADDR_CHECK_EN
        check_vec("hi_err", 32'(d_rsp_err), 32'd1);
        check_vec("hi_data", d_rsp_data, 32'd0);
`else
        check_vec("hi_err", 32'(d_rsp_err), 32'd0);
        check_vec("hi_data", d_rsp_data, 32'h2401_0001);
`endif
        d_addr = 32'h7c;
        tick();
        check_vec("ok_err", 32'(d_rsp_err), 32'd0);
        check_vec("ok_data", d_rsp_data, 32'h8c0a_0008);

        // Async reset with both responses pending
        d_req = 1'b0;
        tick();
        f_req = 1'b1; f_addr = 32'h8; f_rsp_ready = 1'b0;
        d_req = 1'b1; d_addr = 32'h7c; d_rsp_ready = 1'b0;
        tick();
        tick();
        check_vec("pre_rst_f_valid", 32'(f_rsp_valid), 32'd1);
        check_vec("pre_rst_d_valid", 32'(d_rsp_valid), 32'd1);
        check_vec("pre_rst_f_data", f_rsp_data, 32'h0022_1820);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_f_valid", 32'(f_rsp_valid), 32'd0);
        check_vec("async_d_valid", 32'(d_rsp_valid), 32'd0);
        check_vec("async_d_data", d_rsp_data, 32'd0);
        f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("post_rst_f_gnt", 32'(f_gnt), 32'd1);
        check_vec("post_rst_d_gnt", 32'(d_gnt), 32'd0);
        @(posedge clk); #1;
        check_vec("post_rst_f_data", f_rsp_data, 32'h0022_1820);
        check_vec("post_rst_d_valid", 32'(d_rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
